goertzel_bank: RTL and testbench
================================

GOERTZEL_BANK -- requirements
Module: goertzel_bank

Interface
REQ-001 SHALL have parameter NF, default 11: number of frequency channels, range 1..64.
REQ-002 SHALL have parameter DW, default 8: signed sample width.
REQ-003 SHALL have parameter CW, default 16: signed coefficient width, fixed point Q2.(CW-2).
REQ-004 SHALL have parameter AW, default 32: signed state and result width, AW > DW+CW.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1: pulse that begins a block.
REQ-008 SHALL have port num_samp, input, 32: block length N, sampled on start; 0 is treated as 1.
REQ-009 SHALL have ports coef_we, coef_idx, coef_cos2 and coef_sin, inputs, widths 1, clog2(NF), CW and CW: per-channel write of 2cos(w) and sin(w).
REQ-010 SHALL have ports s_valid, s_ready and s_data: in 1, out 1, in DW; sample stream.
REQ-011 SHALL have ports r_valid, r_ready, r_idx, r_re, r_im and r_last: out 1, in 1, out clog2(NF), out AW, out AW, out 1; result stream.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, ACC, FIN and OUT; start in IDLE moves to ACC; start outside IDLE is ignored.
REQ-014 SHALL assert s_ready only in ACC while no channel update is pending; one handshake latches s_data.
REQ-015 SHALL update channels 0..NF-1 after each accepted sample, one channel per cycle, using s = x + ((cos2*s1)>>>(CW-2)) - s2, then s2<=s1 and s1<=s.
REQ-016 SHALL hold s_ready low during the NF update cycles and reassert it on the following cycle, giving at most one sample per NF+1 cycles.
REQ-017 SHALL treat s1 and s2 as 0 during the first sample of a block, so no explicit clear is needed.
REQ-018 SHALL move from ACC to FIN after the last channel update of sample N.
REQ-019 SHALL, in FIN, compute one channel per cycle into a result buffer: re = s1 - ((cos2*s2)>>>(CW-1)) and im = (sin*s2)>>>(CW-2); FIN then moves to OUT.
REQ-020 SHALL use full-width products and arithmetic shifts, and truncate every result to AW bits with two's-complement wrap and no saturation.
REQ-021 SHALL, in OUT, present channels in order 0..NF-1, with r_last=1 only when r_idx=NF-1.
REQ-022 SHALL hold r_valid, r_idx, r_re, r_im and r_last stable while r_valid=1 and r_ready=0.
REQ-023 SHALL return to IDLE on the cycle after the r_last handshake, with r_valid=0.
REQ-024 SHALL accept coef_we only in IDLE; writes while busy, and writes with coef_idx >= NF, SHALL be ignored.
REQ-025 SHALL let a coefficient written in IDLE take effect from the next block.

Reset
REQ-026 SHALL, on rstn low, asynchronously force state IDLE and clear the sample counter, channel counter, state RAM, result buffer and coefficients to 0.
REQ-027 SHALL, during reset, hold s_ready, r_valid, r_last and busy at 0 and r_idx, r_re and r_im at 0.
REQ-028 SHALL abandon any block in progress on a reset assertion mid-operation, with no partial result emitted afterwards.

Configuration
REQ-029 SHALL, when macro GOERTZEL_BANK_POWER_EN is defined, add output r_pwr of width 2*AW, unsigned, = re*re + im*im wrapped to 2*AW; FIN then takes 2 cycles per channel.
REQ-030 SHALL, when GOERTZEL_BANK_POWER_EN is undefined, omit r_pwr and take 1 FIN cycle per channel.

Verification (NF=4, DW=8, CW=16, AW=32)
REQ-031 SHALL cover reset: rstn low with random inputs -> all outputs 0, busy=0, s_ready=0.
REQ-032 SHALL cover fs/4: channel 1 cos2=0, sin=16384, N=4, samples 1,0,-1,0 -> channel 1 gives r_re=0, r_im=-2, and with macro r_pwr=4.
REQ-033 SHALL cover fs/2: channel 2 cos2=-32768, sin=0, N=4, samples 1,-1,1,-1 -> channel 2 gives r_re=-4, r_im=0, and with macro r_pwr=16.
REQ-034 SHALL cover throughput and ignored inputs: s_valid held high -> s_ready high 1 cycle in 5, exactly N handshakes; start and coef_we during ACC ignored.
REQ-035 SHALL cover backpressure: r_ready low for 5 cycles at r_idx=0 -> outputs stable; then r_idx 0,1,2,3 in order, r_last only at 3, busy=0 the next cycle.
REQ-036 SHALL cover mid-block reset: rstn low after 2 samples -> outputs 0 immediately; after coefficient reload, a new block reproduces REQ-032 results.

Source files
------------

// File: rtl/goertzel_bank_if.sv
// rtl/goertzel_bank_if.sv - control, coefficient, sample and result signals of goertzel_bank
// Optional r_pwr member exists only when GOERTZEL_BANK_POWER_EN is defined.
interface goertzel_bank_if #(
    parameter int NF = 11,
    parameter int DW = 8,
    parameter int CW = 16,
    parameter int AW = 32
);
    localparam int IW = (NF > 1) ? $clog2(NF) : 1;

    logic                 start;
    logic [31:0]          num_samp;
    logic                 coef_we;
    logic [IW-1:0]        coef_idx;
    logic signed [CW-1:0] coef_cos2;
    logic signed [CW-1:0] coef_sin;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;
    logic                 r_valid;
    logic                 r_ready;
    logic [IW-1:0]        r_idx;
    logic signed [AW-1:0] r_re;
    logic signed [AW-1:0] r_im;
    logic                 r_last;
    logic                 busy;
`ifdef GOERTZEL_BANK_POWER_EN
    logic [2*AW-1:0]      r_pwr;
`endif

    modport master (
        output start, num_samp, coef_we, coef_idx, coef_cos2, coef_sin,
        output s_valid, s_data, r_ready,
        input  s_ready, r_valid, r_idx, r_re, r_im, r_last, busy
`ifdef GOERTZEL_BANK_POWER_EN
        , input r_pwr
`endif
    );

    modport slave (
        input  start, num_samp, coef_we, coef_idx, coef_cos2, coef_sin,
        input  s_valid, s_data, r_ready,
        output s_ready, r_valid, r_idx, r_re, r_im, r_last, busy
`ifdef GOERTZEL_BANK_POWER_EN
        , output r_pwr
`endif
    );
endinterface

// File: rtl/goertzel_bank.sv
// rtl/goertzel_bank.sv - time-multiplexed bank of NF Goertzel filters over a sample block
// Define GOERTZEL_BANK_POWER_EN to add the r_pwr output (two FIN cycles per channel).
module goertzel_bank #(
    parameter int NF = 11,
    parameter int DW = 8,
    parameter int CW = 16,
    parameter int AW = 32
) (
    input  logic         clk,
    input  logic         rstn,
    goertzel_bank_if.slave bus
);
    localparam int IW = (NF > 1) ? $clog2(NF) : 1;
    localparam int PW = AW + CW;
    localparam logic [IW-1:0] LAST = IW'(NF - 1);

    typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_t;

    state_t               state_q, state_d;
    logic [31:0]          num_q, num_d, samp_q, samp_d;
    logic [IW-1:0]        ch_q, ch_d;
    logic                 upd_q, upd_d;
    logic signed [DW-1:0] x_q, x_d;

    logic signed [AW-1:0] s1_q [NF];
    logic signed [AW-1:0] s2_q [NF];
    logic signed [AW-1:0] re_q [NF];
    logic signed [AW-1:0] im_q [NF];
    logic signed [CW-1:0] cos_q [NF];
    logic signed [CW-1:0] sin_q [NF];
`ifdef GOERTZEL_BANK_POWER_EN
    logic                 ph_q, ph_d;
    logic [2*AW-1:0]      pwr_q [NF];
    logic [2*AW-1:0]      pwr_new;
    logic                 pwr_we;
`endif

    logic signed [AW-1:0] s1_rd, s2_rd, s_new, re_new, im_new;
    logic signed [PW-1:0] cs1_p, cs2_p, ss2_p;
    logic                 s_we, fin_we, coef_ok;

    // The first sample of a block sees zero history, which replaces an explicit clear.
    always_comb begin
        s1_rd  = (samp_q == 32'd0) ? '0 : s1_q[ch_q];
        s2_rd  = (samp_q == 32'd0) ? '0 : s2_q[ch_q];
        cs1_p  = PW'(cos_q[ch_q]) * PW'(s1_rd);
        s_new  = AW'(x_q) + AW'(cs1_p >>> (CW - 2)) - s2_rd;
        cs2_p  = PW'(cos_q[ch_q]) * PW'(s2_q[ch_q]);
        ss2_p  = PW'(sin_q[ch_q]) * PW'(s2_q[ch_q]);
        re_new = s1_q[ch_q] - AW'(cs2_p >>> (CW - 1));
        im_new = AW'(ss2_p >>> (CW - 2));
    end

`ifdef GOERTZEL_BANK_POWER_EN
    always_comb begin
        pwr_new = ((2*AW)'(re_q[ch_q]) * (2*AW)'(re_q[ch_q]))
                + ((2*AW)'(im_q[ch_q]) * (2*AW)'(im_q[ch_q]));
    end
`endif

    assign coef_ok = (state_q == IDLE) && bus.coef_we &&
                     ({{(32-IW){1'b0}}, bus.coef_idx} < 32'(NF));

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        samp_d  = samp_q;
        ch_d    = ch_q;
        upd_d   = upd_q;
        x_d     = x_q;
        s_we    = 1'b0;
        fin_we  = 1'b0;
`ifdef GOERTZEL_BANK_POWER_EN
        ph_d    = ph_q;
        pwr_we  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACC;
                    num_d   = (bus.num_samp == 32'd0) ? 32'd1 : bus.num_samp;
                    samp_d  = '0;
                    ch_d    = '0;
                    upd_d   = 1'b0;
                end
            end
            ACC: begin
                if (!upd_q) begin
                    if (bus.s_valid) begin
                        x_d   = bus.s_data;
                        upd_d = 1'b1;
                        ch_d  = '0;
                    end
                end else begin
                    s_we = 1'b1;
                    if (ch_q == LAST) begin
                        upd_d  = 1'b0;
                        ch_d   = '0;
                        samp_d = samp_q + 32'd1;
                        if (samp_q + 32'd1 == num_q) state_d = FIN;
                    end else begin
                        ch_d = ch_q + IW'(1);
                    end
                end
            end
            FIN: begin
`ifdef GOERTZEL_BANK_POWER_EN
                fin_we = !ph_q;
                pwr_we = ph_q;
                ph_d   = !ph_q;
                if (ph_q) begin
`else
                fin_we = 1'b1;
                begin
`endif
                    if (ch_q == LAST) begin
                        ch_d    = '0;
                        state_d = OUT;
                    end else begin
                        ch_d = ch_q + IW'(1);
                    end
                end
            end
            OUT: begin
                if (bus.r_ready) begin
                    if (ch_q == LAST) begin
                        ch_d    = '0;
                        state_d = IDLE;
                    end else begin
                        ch_d = ch_q + IW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            num_q   <= '0;
            samp_q  <= '0;
            ch_q    <= '0;
            upd_q   <= 1'b0;
            x_q     <= '0;
`ifdef GOERTZEL_BANK_POWER_EN
            ph_q    <= 1'b0;
`endif
            for (int i = 0; i < NF; i++) begin
                s1_q[i]  <= '0;
                s2_q[i]  <= '0;
                re_q[i]  <= '0;
                im_q[i]  <= '0;
                cos_q[i] <= '0;
                sin_q[i] <= '0;
`ifdef GOERTZEL_BANK_POWER_EN
                pwr_q[i] <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            samp_q  <= samp_d;
            ch_q    <= ch_d;
            upd_q   <= upd_d;
            x_q     <= x_d;
`ifdef GOERTZEL_BANK_POWER_EN
            ph_q    <= ph_d;
            if (pwr_we) pwr_q[ch_q] <= pwr_new;
`endif
            if (s_we) begin
                s1_q[ch_q] <= s_new;
                s2_q[ch_q] <= s1_rd;
            end
            if (fin_we) begin
                re_q[ch_q] <= re_new;
                im_q[ch_q] <= im_new;
            end
            if (coef_ok) begin
                cos_q[bus.coef_idx] <= bus.coef_cos2;
                sin_q[bus.coef_idx] <= bus.coef_sin;
            end
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.s_ready = (state_q == ACC) && !upd_q;
    assign bus.r_valid = (state_q == OUT);
    assign bus.r_idx   = bus.r_valid ? ch_q : '0;
    assign bus.r_re    = bus.r_valid ? re_q[ch_q] : '0;
    assign bus.r_im    = bus.r_valid ? im_q[ch_q] : '0;
    assign bus.r_last  = bus.r_valid && (ch_q == LAST);
`ifdef GOERTZEL_BANK_POWER_EN
    assign bus.r_pwr   = bus.r_valid ? pwr_q[ch_q] : '0;
`endif
endmodule

// File: tb/tb_goertzel_bank.sv
// tb/tb_goertzel_bank.sv - directed and random checks of goertzel_bank against a block-level model
module tb_goertzel_bank;
    localparam int NF = 4, DW = 8, CW = 16, AW = 32;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    goertzel_bank_if #(.NF(NF), .DW(DW), .CW(CW), .AW(AW)) bus ();
    goertzel_bank #(.NF(NF), .DW(DW), .CW(CW), .AW(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

    int total = 0;
    int bad = 0;
    int m_cos [NF];
    int m_sin [NF];
    longint e_re [NF];
    longint e_im [NF];
    longint e_pwr [NF];
    logic [63:0] got_re [NF];
    logic [63:0] got_im [NF];
    logic [63:0] got_pwr [NF];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic longint w32(input longint v);
        return longint'(int'(v));
    endfunction

    // Reference: run each channel's recurrence over the whole block, then the final step.
    function automatic void model(input int q[$]);
        for (int c = 0; c < NF; c++) begin
            longint s1 = 0, s2 = 0, s;
            foreach (q[k]) begin
                s  = w32(longint'(q[k]) + ((longint'(m_cos[c]) * s1) >>> 14) - s2);
                s2 = s1;
                s1 = s;
            end
            e_re[c]  = w32(s1 - ((longint'(m_cos[c]) * s2) >>> 15));
            e_im[c]  = w32((longint'(m_sin[c]) * s2) >>> 14);
            e_pwr[c] = e_re[c] * e_re[c] + e_im[c] * e_im[c];
        end
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, ".s_ready"}, 64'(bus.s_ready), 64'd0);
        chk({tag, ".r_valid"}, 64'(bus.r_valid), 64'd0);
        chk({tag, ".busy"}, 64'(bus.busy), 64'd0);
        chk({tag, ".res"}, {26'd0, bus.r_last, bus.r_idx, bus.r_re, 3'd0}, 64'd0);
        chk({tag, ".im"}, 64'(bus.r_im), 64'd0);
`ifdef GOERTZEL_BANK_POWER_EN
        chk({tag, ".pwr"}, bus.r_pwr, 64'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wcoef(input int idx, input int c, input int s);
        bus.coef_we = 1'b1;
        bus.coef_idx = 2'(idx);
        bus.coef_cos2 = 16'(c);
        bus.coef_sin = 16'(s);
        step();
        bus.coef_we = 1'b0;
        m_cos[idx] = c;
        m_sin[idx] = s;
    endtask

    task automatic start_block(input int n);
        bus.num_samp = 32'(n);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic send(input int x);
        int cnt = 0;
        bus.s_valid = 1'b1;
        bus.s_data = 8'(x);
        while (!bus.s_ready && cnt < 100) begin
            step();
            cnt++;
        end
        chk("s_ready_wait", 64'(bus.s_ready), 64'd1);
        step();
        bus.s_valid = 1'b0;
    endtask

    task automatic collect(input bit bp);
        int cnt;
        bus.r_ready = !bp;
        cnt = 0;
        while (!bus.r_valid && cnt < 200) begin
            step();
            cnt++;
        end
        if (bp) begin
            for (int k = 0; k < 5; k++) begin
                chk("bp.valid", 64'(bus.r_valid), 64'd1);
                chk("bp.idx", {61'd0, bus.r_last, bus.r_idx}, 64'd0);
                chk("bp.re", 64'(bus.r_re), e_re[0]);
                chk("bp.im", 64'(bus.r_im), e_im[0]);
                step();
            end
            bus.r_ready = 1'b1;
        end
        for (int i = 0; i < NF; i++) begin
            cnt = 0;
            while (!bus.r_valid && cnt < 200) begin
                step();
                cnt++;
            end
            chk("r_valid", 64'(bus.r_valid), 64'd1);
            chk("r_idx", 64'(bus.r_idx), 64'(i));
            chk("r_last", 64'(bus.r_last), 64'(i == NF - 1));
            got_re[i] = 64'(bus.r_re);
            got_im[i] = 64'(bus.r_im);
            chk("r_re", got_re[i], e_re[i]);
            chk("r_im", got_im[i], e_im[i]);
`ifdef GOERTZEL_BANK_POWER_EN
            got_pwr[i] = bus.r_pwr;
            chk("r_pwr", got_pwr[i], e_pwr[i]);
`endif
            step();
        end
        bus.r_ready = 1'b0;
        chk("busy_after", 64'(bus.busy), 64'd0);
        chk("valid_after", 64'(bus.r_valid), 64'd0);
    endtask

    task automatic run_block(input int q[$], input int n);
        model(q);
        start_block(n);
        foreach (q[k]) send(q[k]);
        collect(1'b0);
    endtask

    initial begin
        int q[$];
        int hs, cyc, last_cyc, extra, n;
        bus.start = 0; bus.num_samp = 0; bus.coef_we = 0; bus.coef_idx = 0;
        bus.coef_cos2 = 0; bus.coef_sin = 0; bus.s_valid = 0; bus.s_data = 0;
        bus.r_ready = 0;
        for (int c = 0; c < NF; c++) begin m_cos[c] = 0; m_sin[c] = 0; end

        // Reset with random inputs.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.start = 1'($urandom); bus.s_valid = 1'($urandom);
            bus.s_data = 8'($urandom); bus.r_ready = 1'($urandom);
            bus.coef_we = 1'($urandom); bus.num_samp = $urandom;
            #1 chk_zero("reset");
        end
        bus.start = 0; bus.s_valid = 0; bus.r_ready = 0; bus.coef_we = 0;
        @(negedge clk);
        rstn = 1'b1;
        step();

        // fs/4 on channel 1, other channels random.
        for (int c = 0; c < NF; c++)
            wcoef(c, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
        wcoef(1, 0, 16384);
        q = '{1, 0, -1, 0};
        run_block(q, 4);
        chk("fs4.re", got_re[1], 64'd0);
        chk("fs4.im", got_im[1], -64'sd2);
`ifdef GOERTZEL_BANK_POWER_EN
        chk("fs4.pwr", got_pwr[1], 64'd4);
`endif

        // fs/2 on channel 2.
        wcoef(2, -32768, 0);
        q = '{1, -1, 1, -1};
        run_block(q, 4);
        chk("fs2.re", got_re[2], -64'sd4);
        chk("fs2.im", got_im[2], 64'd0);
`ifdef GOERTZEL_BANK_POWER_EN
        chk("fs2.pwr", got_pwr[2], 64'd16);
`endif

        // Throughput with s_valid held high, ignored start/coef_we in ACC, then backpressure.
        q = {};
        for (int k = 0; k < 5; k++) q.push_back($urandom_range(0, 255) - 128);
        model(q);
        start_block(5);
        bus.s_valid = 1'b1;
        hs = 0; cyc = 0; last_cyc = 0;
        while (hs < 5 && cyc < 200) begin
            bus.s_data = 8'(q[hs]);
            if (bus.s_ready) begin
                if (hs > 0) chk("tp.gap", 64'(cyc - last_cyc), 64'd5);
                last_cyc = cyc;
                hs++;
            end
            if (hs == 2 && cyc == last_cyc) begin
                bus.start = 1'b1; bus.num_samp = 9; bus.coef_we = 1'b1;
                bus.coef_idx = 0; bus.coef_cos2 = 16'($urandom); bus.coef_sin = 16'($urandom);
            end else begin
                bus.start = 1'b0; bus.coef_we = 1'b0;
            end
            step();
            cyc++;
        end
        bus.start = 1'b0; bus.coef_we = 1'b0;
        chk("tp.hs", 64'(hs), 64'd5);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.s_ready) extra++;
            step();
        end
        bus.s_valid = 1'b0;
        chk("tp.extra", 64'(extra), 64'd0);
        collect(1'b1);

        // Mid-block reset after two samples.
        start_block(4);
        send(1);
        send(0);
        rstn = 1'b0;
        #1 chk_zero("midrst");
        @(negedge clk);
        chk_zero("midrst_hold");
        rstn = 1'b1;
        step();
        chk("midrst.busy", 64'(bus.busy), 64'd0);
        for (int c = 0; c < NF; c++) begin m_cos[c] = 0; m_sin[c] = 0; end
        wcoef(1, 0, 16384);
        q = '{1, 0, -1, 0};
        run_block(q, 4);
        chk("rst_fs4.re", got_re[1], 64'd0);
        chk("rst_fs4.im", got_im[1], -64'sd2);

        // Random blocks, including N=0 treated as one sample.
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < NF; c++)
                wcoef(c, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768);
            n = (b == 0) ? 0 : $urandom_range(1, 8);
            q = {};
            for (int k = 0; k < ((n == 0) ? 1 : n); k++) q.push_back($urandom_range(0, 255) - 128);
            run_block(q, n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
